// File: rtl/dac_ramp_interp_pkg.sv
// Shared types and width helpers for the DAC ramp interpolator.
// Module widths: DELTA_W = DAC_WIDTH+1, ACC_W = DAC_WIDTH+LOG2_STEPS+1.
package spgd_dac_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } ramp_state_e;

    localparam int unsigned DEF_DAC_WIDTH = 12;
    localparam int unsigned DEF_NUM_STEPS = 1024;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned delta_width(input int unsigned dac_width);
        return dac_width + 1;
    endfunction

    function automatic int unsigned acc_width(input int unsigned dac_width,
                                              input int unsigned num_steps);
        return dac_width + clog2(num_steps) + 1;
    endfunction

endpackage

// File: rtl/dac_ramp_interp_if.sv
// Setpoint/sample bus between the SPGD control logic (master) and the ramp interpolator (slave).
interface dac_ramp_interp_if
    import spgd_dac_pkg::*;
#(
    parameter int unsigned DAC_WIDTH = DEF_DAC_WIDTH
) ();

    logic                        en;
    logic                        in_valid;
    logic signed [DAC_WIDTH-1:0] in_data;
    logic                        in_ready;
    logic                        done;
    logic signed [DAC_WIDTH-1:0] data_out;

    modport master (
        output en, in_valid, in_data,
        input  in_ready, done, data_out
    );

    modport slave (
        input  en, in_valid, in_data,
        output in_ready, done, data_out
    );

endinterface

// File: rtl/dac_ramp_acc.sv
// Ramp datapath: latched delta, fixed-point accumulator (sample << LOG2_STEPS) and step counter.
// A load performs the first step in the same cycle so the ramp output moves one clock after accept.
module dac_ramp_acc
    import spgd_dac_pkg::*;
#(
    parameter int unsigned DAC_WIDTH = DEF_DAC_WIDTH,
    parameter int unsigned NUM_STEPS = DEF_NUM_STEPS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic                        step,
    input  logic                        realign,
    input  logic signed [DAC_WIDTH-1:0] target,
    output logic signed [DAC_WIDTH-1:0] sample,
    output logic                        last_step
);

    localparam int unsigned LOG2_STEPS = clog2(NUM_STEPS);
    localparam int unsigned DELTA_W    = delta_width(DAC_WIDTH);
    localparam int unsigned ACC_W      = acc_width(DAC_WIDTH, NUM_STEPS);

    logic signed [DELTA_W-1:0]    delta_q, delta_d, new_delta;
    logic signed [ACC_W-1:0]      acc_q, acc_d;
    logic        [LOG2_STEPS-1:0] cnt_q, cnt_d;

    assign sample    = acc_q[LOG2_STEPS +: DAC_WIDTH];
    assign last_step = (cnt_q == LOG2_STEPS'(NUM_STEPS - 1));

    always_comb begin
        delta_d   = delta_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        new_delta = {target[DAC_WIDTH-1], target} - {sample[DAC_WIDTH-1], sample};
        if (load) begin
            delta_d = new_delta;
            acc_d   = acc_q + {{LOG2_STEPS{new_delta[DELTA_W-1]}}, new_delta};
            cnt_d   = LOG2_STEPS'(1);
        end else if (step) begin
            acc_d = acc_q + {{LOG2_STEPS{delta_q[DELTA_W-1]}}, delta_q};
            cnt_d = cnt_q + 1'b1;
        end else if (realign) begin
            // drop the fraction so the next ramp starts exactly at the held sample
            acc_d = {acc_q[ACC_W-1:LOG2_STEPS], {LOG2_STEPS{1'b0}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            delta_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            delta_q <= delta_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/dac_ramp_interp.sv
// Expands each accepted DAC setpoint into NUM_STEPS per-clock samples ramping linearly to it.
// Build option: DAC_RAMP_OFFSET_BINARY_EN inverts the output MSB for offset-binary DACs.
module dac_ramp_interp
    import spgd_dac_pkg::*;
#(
    parameter int unsigned DAC_WIDTH = DEF_DAC_WIDTH,
    parameter int unsigned NUM_STEPS = DEF_NUM_STEPS
) (
    input  logic              CLK,
    input  logic              RST,
    dac_ramp_interp_if.slave  bus
);

    ramp_state_e                 state_q, state_d;
    logic                        done_q, done_d;
    logic                        load, step, realign, last_step;
    logic signed [DAC_WIDTH-1:0] sample;

    assign bus.in_ready = (state_q == IDLE) && bus.en && !RST;
    assign bus.done     = done_q;

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        realign = 1'b0;
        if (!bus.en) begin
            state_d = IDLE;
            realign = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        load    = 1'b1;
                        state_d = RAMP;
                    end
                end
                RAMP: begin
                    step = 1'b1;
                    if (last_step) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    dac_ramp_acc #(
        .DAC_WIDTH (DAC_WIDTH),
        .NUM_STEPS (NUM_STEPS)
    ) u_acc (
        .clk       (CLK),
        .rst       (RST),
        .load      (load),
        .step      (step),
        .realign   (realign),
        .target    (bus.in_data),
        .sample    (sample),
        .last_step (last_step)
    );

`ifdef DAC_RAMP_OFFSET_BINARY_EN
    assign bus.data_out = {~sample[DAC_WIDTH-1], sample[DAC_WIDTH-2:0]};
`else
    assign bus.data_out = sample;
`endif

endmodule

// File: tb/tb_dac_ramp_interp.sv
// Bench for dac_ramp_interp: NUM_STEPS=4 and NUM_STEPS=1024 instances against a floor-division ramp model.
// Honours DAC_RAMP_OFFSET_BINARY_EN for the expected output encoding.
module tb_dac_ramp_interp;

`ifdef DAC_RAMP_OFFSET_BINARY_EN
    localparam logic [11:0] OBM = 12'h800;
`else
    localparam logic [11:0] OBM = 12'h000;
`endif

    logic CLK;
    logic RST;

    logic              en_v    [2];
    logic              valid_v [2];
    logic signed [11:0] data_v [2];
    logic signed [11:0] dout   [2];
    logic              rdy     [2];
    logic              dn      [2];

    int checks;
    int errors;

    // model state (per instance)
    int steps_n [2] = '{4, 1024};
    int m_out   [2];
    int m_start [2];
    int m_delta [2];
    int m_i     [2];
    bit m_busy  [2];
    bit m_done  [2];

    int t1 [4] = '{25, 50, 75, 100};
    int t2 [4] = '{50, 0, -50, -100};
    int t3 [4] = '{-1025, -1, 1023, 2047};
    int t4 [4] = '{75, -50, -175, -300};
    int t5 [4] = '{51, 51, 51, 52};

    dac_ramp_interp_if #(.DAC_WIDTH(12)) if0 ();
    dac_ramp_interp_if #(.DAC_WIDTH(12)) if1 ();

    assign if0.en       = en_v[0];
    assign if0.in_valid = valid_v[0];
    assign if0.in_data  = data_v[0];
    assign if1.en       = en_v[1];
    assign if1.in_valid = valid_v[1];
    assign if1.in_data  = data_v[1];
    assign dout[0] = if0.data_out;
    assign dout[1] = if1.data_out;
    assign rdy[0]  = if0.in_ready;
    assign rdy[1]  = if1.in_ready;
    assign dn[0]   = if0.done;
    assign dn[1]   = if1.done;

    dac_ramp_interp #(.DAC_WIDTH(12), .NUM_STEPS(4)) dut0 (
        .CLK (CLK),
        .RST (RST),
        .bus (if0)
    );

    dac_ramp_interp #(.DAC_WIDTH(12), .NUM_STEPS(1024)) dut1 (
        .CLK (CLK),
        .RST (RST),
        .bus (if1)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic int fdiv(input int a, input int n);
        if (a >= 0) return a / n;
        return -((-a + n - 1) / n);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk12(input string name, input logic [11:0] act, input logic [11:0] exp);
        check(name, {20'd0, act}, {20'd0, exp});
    endtask

    // Ramp sample i of n: start + floor(delta*i/n)
    task automatic model_upd(input int idx);
        if (RST) begin
            m_busy[idx] = 1'b0;
            m_done[idx] = 1'b0;
            m_out[idx]  = 0;
        end else if (!en_v[idx]) begin
            m_busy[idx] = 1'b0;
            m_done[idx] = 1'b0;
        end else if (!m_busy[idx]) begin
            m_done[idx] = 1'b0;
            if (valid_v[idx]) begin
                m_start[idx] = m_out[idx];
                m_delta[idx] = int'(data_v[idx]) - m_out[idx];
                m_i[idx]     = 1;
                m_out[idx]   = m_start[idx] + fdiv(m_delta[idx], steps_n[idx]);
                m_busy[idx]  = 1'b1;
            end
        end else begin
            m_i[idx]   = m_i[idx] + 1;
            m_out[idx] = m_start[idx] + fdiv(m_delta[idx] * m_i[idx], steps_n[idx]);
            if (m_i[idx] == steps_n[idx]) begin
                m_busy[idx] = 1'b0;
                m_done[idx] = 1'b1;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge CLK or posedge RST);
            for (int i = 0; i < 2; i++) model_upd(i);
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            for (int i = 0; i < 2; i++) begin
                chk12($sformatf("model_dout%0d", i), dout[i], 12'(m_out[i]) ^ OBM);
                check($sformatf("model_ready%0d", i), {31'd0, rdy[i]},
                      {31'd0, !m_busy[i] && en_v[i] && !RST});
                check($sformatf("model_done%0d", i), {31'd0, dn[i]}, {31'd0, m_done[i]});
            end
        end
    end

    task automatic accept(input int idx, input int val);
        int n;
        n = 0;
        @(negedge CLK);
        while (!rdy[idx] && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (!rdy[idx]) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout%0d: ready stuck low, required high", idx);
        end
        valid_v[idx] = 1'b1;
        data_v[idx]  = 12'(val);
        @(posedge CLK);
        #1 valid_v[idx] = 1'b0;
    endtask

    task automatic ramp4(input string name, input int exp [4]);
        for (int j = 0; j < 4; j++) begin
            @(negedge CLK);
            chk12($sformatf("%s_out%0d", name, j), dout[0], 12'(exp[j]) ^ OBM);
            check($sformatf("%s_done%0d", name, j), {31'd0, dn[0]}, {31'd0, j == 3});
            check($sformatf("%s_ready%0d", name, j), {31'd0, rdy[0]}, {31'd0, j == 3});
        end
    endtask

    task automatic wait_done1(input string name, input bit mono);
        int c;
        int prev;
        int bad;
        c    = 0;
        bad  = 0;
        prev = int'(dout[1]);
        while (c < 1100) begin
            @(negedge CLK);
            c++;
            if (int'(dout[1]) < prev) bad++;
            prev = int'(dout[1]);
            if (dn[1]) break;
        end
        check({name, "_latency"}, c, 1024);
        if (mono) check({name, "_monotonic_violations"}, bad, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RST = 1'b1;
        for (int i = 0; i < 2; i++) begin
            en_v[i]    = 1'b1;
            valid_v[i] = 1'b0;
            data_v[i]  = '0;
        end
        repeat (2) @(negedge CLK);
        chk12("rst_dout0", dout[0], OBM);
        chk12("rst_dout1", dout[1], OBM);
        check("rst_ready0", {31'd0, rdy[0]}, 0);
        check("rst_done0", {31'd0, dn[0]}, 0);
        #2 RST = 1'b0;

        accept(0, 100);
        ramp4("t1", t1);
        accept(0, -100);
        ramp4("t2", t2);

        // setpoint held valid through a ramp: only the value present when ready returns counts
        accept(0, 200);
        for (int j = 0; j < 4; j++) begin
            @(negedge CLK);
            valid_v[0] = 1'b1;
            if (j < 3) begin
                data_v[0] = 12'(700 + j * 111);
            end else begin
                chk12("t4_hold_out", dout[0], 12'(200) ^ OBM);
                check("t4_hold_done", {31'd0, dn[0]}, 1);
                data_v[0] = -12'sd300;
            end
        end
        @(posedge CLK);
        #1 valid_v[0] = 1'b0;
        ramp4("t4", t4);

        accept(0, -2048);
        repeat (4) @(negedge CLK);
        chk12("t3_low", dout[0], 12'h800 ^ OBM);
        accept(0, 2047);
        ramp4("t3", t3);
        accept(0, -2048);
        repeat (4) @(negedge CLK);
        chk12("t3_back", dout[0], 12'h800 ^ OBM);

        accept(1, -2048);
        wait_done1("t3b_down", 1'b0);
        accept(1, 2047);
        wait_done1("t3b_up", 1'b1);
        chk12("t3b_final", dout[1], 12'h7ff ^ OBM);

        accept(0, 0);
        repeat (4) @(negedge CLK);
        accept(0, 100);
        @(negedge CLK);
        chk12("t5_k1", dout[0], 12'd25 ^ OBM);
        @(negedge CLK);
        chk12("t5_k2", dout[0], 12'd50 ^ OBM);
        en_v[0] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge CLK);
            chk12("t5_hold", dout[0], 12'd50 ^ OBM);
            check("t5_no_done", {31'd0, dn[0]}, 0);
        end
        @(posedge CLK);
        #1 en_v[0] = 1'b1;
        accept(0, 50);
        for (int j = 0; j < 4; j++) begin
            @(negedge CLK);
            chk12("t5_same", dout[0], 12'd50 ^ OBM);
            check("t5_same_done", {31'd0, dn[0]}, {31'd0, j == 3});
        end

        // abort leaves a fractional accumulator; the next ramp must start from the held sample
        accept(0, 53);
        @(negedge CLK);
        @(negedge CLK);
        chk12("t5b_k2", dout[0], 12'd51 ^ OBM);
        en_v[0] = 1'b0;
        repeat (2) @(negedge CLK);
        @(posedge CLK);
        #1 en_v[0] = 1'b1;
        accept(0, 52);
        ramp4("t5b", t5);

        accept(0, 100);
        @(negedge CLK);
        chk12("t6_k1", dout[0], 12'd64 ^ OBM);
        #3 RST = 1'b1;
        #1;
        chk12("t6_rst_dout0", dout[0], OBM);
        chk12("t6_rst_dout1", dout[1], OBM);
        check("t6_rst_ready", {31'd0, rdy[0]}, 0);
        check("t6_rst_done", {31'd0, dn[0]}, 0);
        repeat (2) @(negedge CLK);
        #2 RST = 1'b0;
        accept(0, 100);
        ramp4("t6", t1);
        chk12("t6_final", dout[0], 12'd100 ^ OBM);

        repeat (3) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
